crc_frame_serializer: RTL and testbench

// - Parametrised successor to the 2:1 frame-assembly mux in the CRC datapath.
// - Builds a message frame {header, tail}, where tail is either CRC_W zero bits (augment mode, for CRC generation) or a supplied CRC remainder (append mode, for transmit/check).
// - Registers the frame, then streams it bit-serially to the CRC shift engine over a valid/ready handshake.

---
 rtl/crc_frame_serializer.sv | 90 +++++++++
 tb/tb_crc_frame_serializer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/crc_frame_serializer.sv
// Assembles {header, tail} into a frame, where the tail is either a zero field or a supplied CRC,
// then streams the frame one bit per valid/ready beat to the CRC shift engine.
module crc_frame_serializer #(
  parameter int DATA_W    = 4,
  parameter int CRC_W     = 16,
  parameter int MSB_FIRST = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  input  logic [CRC_W-1:0]          in_crc,
  input  logic                      append_sel,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_bit,
  output logic                      out_last,
  output logic [DATA_W+CRC_W-1:0]   frame_word,
  output logic                      busy
);

  localparam int FRAME_W = DATA_W + CRC_W;
  localparam int CNT_W   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [FRAME_W-1:0]   r_shreg;
  logic [FRAME_W-1:0]   r_frameWord;
  logic [CNT_W-1:0]     r_cnt;
  logic [FRAME_W-1:0]   w_frame;
  logic                 w_accept;
  logic                 w_beat;

  assign w_frame    = {in_data, append_sel ? in_crc : {CRC_W{1'b0}}};
  assign w_accept   = in_valid && in_ready;
  assign w_beat     = out_valid && out_ready;
  assign frame_word = r_frameWord;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = SHIFT;
      SHIFT:   if (w_beat && out_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // in_ready is gated by rst so every output reads zero while reset is held
  always_comb begin
    in_ready  = (r_state == IDLE) && !rst;
    out_valid = (r_state == SHIFT);
    busy      = (r_state == SHIFT);
    out_last  = (r_state == SHIFT) && (r_cnt == '0);
    out_bit   = (MSB_FIRST != 0) ? r_shreg[FRAME_W-1] : r_shreg[0];
  end

  // Zero fill leaves the shift register empty once a frame has fully drained
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg     <= '0;
      r_frameWord <= '0;
      r_cnt       <= '0;
    end else if (w_accept) begin
      r_shreg     <= w_frame;
      r_frameWord <= w_frame;
      r_cnt       <= CNT_W'(FRAME_W - 1);
    end else if (w_beat) begin
      if (MSB_FIRST != 0) begin
        r_shreg <= {r_shreg[FRAME_W-2:0], 1'b0};
      end else begin
        r_shreg <= {1'b0, r_shreg[FRAME_W-1:1]};
      end
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_crc_frame_serializer.sv
// Bench for crc_frame_serializer: an MSB-first and an LSB-first instance share stimulus,
// a table of frames drives both, and per-instance queues hold the expected bit streams.
module tb_crc_frame_serializer;

  typedef struct {
    logic [3:0]  data;
    logic [15:0] crc;
    logic        app;
    logic [19:0] expFrame;
  } vec_t;

  typedef struct packed {
    logic b;
    logic last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inValid = 1'b0;
  logic [3:0]  inData = '0;
  logic [15:0] inCrc = '0;
  logic        appendSel = 1'b0;
  logic        outReady = 1'b1;

  logic        inReadyM, outValidM, outBitM, outLastM, busyM;
  logic [19:0] frameWordM;
  logic        inReadyL, outValidL, outBitL, outLastL, busyL;
  logic [19:0] frameWordL;

  beat_t qMsb[$];
  beat_t qLsb[$];
  beat_t eM, eL;
  vec_t  vecs[5];

  int nPass = 0;
  int nTotal = 0;
  bit stallM = 1'b0;
  logic heldBit, heldLast;

  crc_frame_serializer #(.DATA_W(4), .CRC_W(16), .MSB_FIRST(1)) dutMsb (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReadyM),
    .in_data(inData), .in_crc(inCrc), .append_sel(appendSel),
    .out_valid(outValidM), .out_ready(outReady), .out_bit(outBitM),
    .out_last(outLastM), .frame_word(frameWordM), .busy(busyM)
  );

  crc_frame_serializer #(.DATA_W(4), .CRC_W(16), .MSB_FIRST(0)) dutLsb (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReadyL),
    .in_data(inData), .in_crc(inCrc), .append_sel(appendSel),
    .out_valid(outValidL), .out_ready(outReady), .out_bit(outBitL),
    .out_last(outLastL), .frame_word(frameWordL), .busy(busyL)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTotal++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic pushFrame(input logic [19:0] f);
    for (int i = 19; i >= 0; i--) qMsb.push_back('{b: f[i], last: (i == 0)});
    for (int i = 0; i < 20; i++) qLsb.push_back('{b: f[i], last: (i == 19)});
  endtask

  task automatic applyStimulus(input logic [3:0] d, input logic [15:0] c, input logic a,
                               input logic [19:0] expFrame);
    @(posedge clk); #1;
    inData = d; inCrc = c; appendSel = a; inValid = 1'b1;
    @(negedge clk);
    checkOutput("acceptReadyMsb", inReadyM, 1);
    checkOutput("acceptReadyLsb", inReadyL, 1);
    pushFrame(expFrame);
    @(posedge clk); #1;
    inValid = 1'b0;
  endtask

  task automatic waitFrameDone(input bit bp, input bit poke);
    bit done = 1'b0;
    for (int c = 0; c < 600 && !done; c++) begin
      if (bp) outReady = 1'($urandom_range(0, 1));
      if (poke && c == 3) begin
        inValid = 1'b1; inData = 4'h7; inCrc = 16'hBEEF; appendSel = 1'b1;
      end else begin
        inValid = 1'b0;
      end
      @(negedge clk);
      if (poke && c == 3) checkOutput("ignoredInReady", inReadyM, 0);
      @(posedge clk); #1;
      if (qMsb.size() == 0 && qLsb.size() == 0 && !outValidM && !outValidL) done = 1'b1;
    end
    outReady = 1'b1;
    inValid = 1'b0;
    if (!done) checkOutput("frameTimeout", 0, 1);
  endtask

  // Scoreboard for the MSB-first instance, including hold checks across stalled beats
  always @(negedge clk) begin
    if (outValidM) begin
      checkOutput("busyMsb", busyM, 1);
      if (stallM) begin
        checkOutput("stallHoldBit", outBitM, heldBit);
        checkOutput("stallHoldLast", outLastM, heldLast);
      end
      if (outReady) begin
        if (qMsb.size() == 0) checkOutput("msbUnexpectedBeat", 1, 0);
        else begin
          eM = qMsb.pop_front();
          checkOutput("msbBit", outBitM, eM.b);
          checkOutput("msbLast", outLastM, eM.last);
        end
      end
      stallM = !outReady;
      heldBit = outBitM;
      heldLast = outLastM;
    end else begin
      stallM = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (outValidL && outReady) begin
      if (qLsb.size() == 0) checkOutput("lsbUnexpectedBeat", 1, 0);
      else begin
        eL = qLsb.pop_front();
        checkOutput("lsbBit", outBitL, eL.b);
        checkOutput("lsbLast", outLastL, eL.last);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{4'hA, 16'h1234, 1'b1, 20'hA1234};
    vecs[1] = '{4'h5, 16'hFFFF, 1'b0, 20'h50000};
    vecs[2] = '{4'h3, 16'h0001, 1'b1, 20'h30001};
    vecs[3] = '{4'hF, 16'hABCD, 1'b0, 20'hF0000};
    vecs[4] = '{4'hC, 16'h8001, 1'b1, 20'hC8001};

    // Asynchronous reset before any clock edge
    #1 rst = 1'b1;
    #1;
    checkOutput("rstInReady", inReadyM, 0);
    checkOutput("rstOutValid", outValidM, 0);
    checkOutput("rstOutBit", outBitM, 0);
    checkOutput("rstOutLast", outLastM, 0);
    checkOutput("rstBusy", busyM, 0);
    checkOutput("rstFrameWord", frameWordM, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checkOutput("postRstInReady", inReadyM, 1);
    checkOutput("postRstOutValid", outValidM, 0);

    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v].data, vecs[v].crc, vecs[v].app, vecs[v].expFrame);
      waitFrameDone(1'b0, 1'b0);
      checkOutput("frameWordMsb", frameWordM, vecs[v].expFrame);
      checkOutput("frameWordLsb", frameWordL, vecs[v].expFrame);
      checkOutput("idleInReady", inReadyM, 1);
      checkOutput("idleBusy", busyM, 0);
    end

    // Backpressure with an in_valid pulse that must be ignored mid-frame
    applyStimulus(4'hA, 16'h1234, 1'b1, 20'hA1234);
    waitFrameDone(1'b1, 1'b1);
    checkOutput("bpFrameWord", frameWordM, 20'hA1234);
    checkOutput("bpFrameWordLsb", frameWordL, 20'hA1234);

    // Reset after 7 accepted bits, then a clean frame
    applyStimulus(4'hA, 16'h1234, 1'b1, 20'hA1234);
    for (int c = 0; c < 100 && qMsb.size() > 13; c++) begin
      @(posedge clk); #1;
    end
    checkOutput("midRstBeatsLeft", qMsb.size(), 13);
    #1 rst = 1'b1;
    #1;
    checkOutput("midRstOutValid", outValidM, 0);
    checkOutput("midRstOutValidLsb", outValidL, 0);
    checkOutput("midRstBusy", busyM, 0);
    checkOutput("midRstInReady", inReadyM, 0);
    checkOutput("midRstOutLast", outLastM, 0);
    checkOutput("midRstFrameWord", frameWordM, 0);
    qMsb.delete();
    qLsb.delete();
    @(posedge clk); #1 rst = 1'b0;
    #1;
    checkOutput("midRstRelease", inReadyM, 1);
    applyStimulus(4'h3, 16'h0001, 1'b1, 20'h30001);
    waitFrameDone(1'b0, 1'b0);
    checkOutput("afterRstFrameWord", frameWordM, 20'h30001);

    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
